// File: rtl/ksa16_sched_pkg.sv
// ksa16_sched_pkg: shared FSM state and op encodings for the KSA16 scheduler
package ksa16_sched_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_INC  = 3'd3,
    S_RESP = 3'd4
  } state_t;
  localparam logic OP_ADD16 = 1'b0;
  localparam logic OP_ADD32 = 1'b1;
endpackage

// File: rtl/ksa16_sched_arb.sv
// rr_arbiter: combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);
  int c;
  always_comb begin
    c   = 0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      c = (int'(ptr) + k) % N_REQ;
      if (!any && req[c]) begin
        any = 1'b1;
        idx = ID_W'(c);
      end
    end
    gnt = any ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/ksa16_sched_ksa.sv
// ksa16: 16-bit Kogge-Stone adder, no carry-in
module ksa16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g [0:4];
  logic [15:0] p [0:3];
  assign g[0] = a & b;
  assign p[0] = a ^ b;
  for (genvar l = 0; l < 4; l++) begin : g_lvl
    localparam int d = 1 << l;
    assign g[l+1] = g[l] | (p[l] & {g[l][15-d:0], {d{1'b0}}});
    if (l < 3) begin : g_p
      assign p[l+1] = p[l] & {p[l][15-d:0], {d{1'b1}}};
    end
  end
  assign sum  = p[0] ^ {g[4][14:0], 1'b0};
  assign cout = g[4][15];
endmodule

// File: rtl/ksa16_sched.sv
// ksa16_sched: round-robin scheduler sharing one KSA16 for 16/32-bit adds
module ksa16_sched
  import ksa16_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0]      req_op,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy
);
  state_t state, nxt;
  logic [ID_W-1:0] ptr, id, w;
  logic [N_REQ-1:0] gnt;
  logic any, op, c0, c1, cout, co;
  logic [31:0] a, b, res;
  logic [15:0] tmp, x, y, s;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (w),
    .any (any)
  );
  ksa16 u_ksa (
    .a    (x),
    .b    (y),
    .sum  (s),
    .cout (co)
  );
  // INC pass folds the low-half carry into the upper half
  always_comb begin
    x = state == S_LO ? a[15:0] : state == S_HI ? a[31:16] : tmp;
    y = state == S_LO ? b[15:0] : state == S_HI ? b[31:16] : {15'b0, c0};
  end
  assign req_ready = state == S_IDLE ? gnt : '0;
  assign busy      = state != S_IDLE;
  assign rsp_valid = state == S_RESP;
  assign rsp_id    = id;
  assign rsp_sum   = res;
  assign rsp_cout  = cout;
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  nxt = any ? S_LO : S_IDLE;
      S_LO:    nxt = op == OP_ADD32 ? S_HI : S_RESP;
      S_HI:    nxt = S_INC;
      S_INC:   nxt = S_RESP;
      S_RESP:  nxt = rsp_ready ? S_IDLE : S_RESP;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ptr  <= '0;
      id   <= '0;
      op   <= OP_ADD16;
      a    <= '0;
      b    <= '0;
      res  <= '0;
      tmp  <= '0;
      c0   <= 1'b0;
      c1   <= 1'b0;
      cout <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (any) begin
          op <= req_op[w];
          a  <= req_a[32*int'(w) +: 32];
          b  <= req_b[32*int'(w) +: 32];
          id <= w;
        end
        S_LO: begin
          res[15:0] <= s;
          c0        <= co;
          if (op == OP_ADD16) begin
            res[31:16] <= '0;
            cout       <= co;
          end
        end
        S_HI: begin
          tmp <= s;
          c1  <= co;
        end
        S_INC: begin
          res[31:16] <= s;
          cout       <= c1 | co;
        end
        S_RESP: if (rsp_ready) ptr <= id == ID_W'(N_REQ-1) ? '0 : id + ID_W'(1);
        default: ;
      endcase
    end
  end
endmodule
